// File: rtl/aidc_lite_ahb_sram_slave.sv
// AHB-Lite style slave in front of a word-organised SRAM array.
// Decodes each beat on its own; errors take the two-cycle ERROR response, OKAY phases add WAIT_CYCLES wait states.
module aidc_lite_ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel_i,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic [2:0]  hburst_i,
  input  logic [31:0] hwdata_i,
  input  logic        hready_i,
  output logic        hreadyout_o,
  output logic [1:0]  hresp_o,
  output logic [31:0] hrdata_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  // Handshake: a data phase ends on any rising edge where hready_i is high;
  // the next address phase is sampled on that same edge.

  state_t          state_q, state_d;
  logic            capture;
  logic [32:0]     off;
  logic            range_err, size_err, align_err, addr_err;
  logic            dp_ok, dp_write;
  logic [1:0]      dp_size, dp_lo;
  logic [AW-1:0]   dp_idx;
  logic [3:0]      cnt_q;
  logic            complete_ok;
  logic [3:0]      be;
  logic [31:0]     wmask;
  logic [31:0]     mem_rd [DEPTH_WORDS];
  logic            unused_inputs;

  assign unused_inputs = ^{hburst_i, htrans_i[0]};

  assign capture   = hsel_i & hready_i & htrans_i[1];
  // Bit 32 of the offset is the borrow, i.e. the address lies below BASE_ADDR.
  assign off       = {1'b0, haddr_i} - {1'b0, BASE_ADDR};
  assign range_err = off[32] | (|off[31:AW+2]);
  assign size_err  = hsize_i[2] | (hsize_i[1:0] == 2'b11);
  assign align_err = ((hsize_i == 3'b001) & off[0]) | ((hsize_i == 3'b010) & (|off[1:0]));
  assign addr_err  = range_err | size_err | align_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        if (!capture)              state_d = S_IDLE;
        else if (addr_err)         state_d = S_ERR1;
        else if (WAIT_CYCLES != 0) state_d = S_WAIT;
        else                       state_d = S_IDLE;
      end
      S_WAIT:  state_d = (cnt_q == 4'd1) ? S_IDLE : S_WAIT;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_ok    <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 2'b00;
      dp_lo    <= 2'b00;
      dp_idx   <= '0;
      cnt_q    <= 4'd0;
    end else begin
      if (hready_i) dp_ok <= capture & ~addr_err;
      if (capture) begin
        dp_write <= hwrite_i;
        dp_size  <= hsize_i[1:0];
        dp_lo    <= off[1:0];
        dp_idx   <= off[AW+1:2];
      end
      if (capture & ~addr_err)   cnt_q <= WAIT_INIT;
      else if (state_q == S_WAIT) cnt_q <= cnt_q - 4'd1;
    end
  end

  assign complete_ok = (state_q == S_IDLE) & dp_ok;

  always_comb begin
    be = 4'b0000;
    case (dp_size)
      2'b00:   be = 4'b0001 << dp_lo;
      2'b01:   be = dp_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  for (genvar gi = 0; gi < int'(DEPTH_WORDS); gi++) begin : g_word
    logic [31:0] word_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        word_q <= '0;
      else if (complete_ok && dp_write && (dp_idx == AW'(gi)))
        word_q <= (word_q & ~wmask) | (hwdata_i & wmask);
    end
    assign mem_rd[gi] = word_q;
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 2'b00;
    hrdata_o    = '0;
    case (state_q)
      S_WAIT: hreadyout_o = 1'b0;
      S_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 2'b01;
      end
      S_ERR2: hresp_o = 2'b01;
      default: begin
        if (complete_ok && !dp_write) hrdata_o = mem_rd[dp_idx];
      end
    endcase
  end

endmodule

// File: tb/tb_aidc_lite_ahb_sram_slave.sv
// Bench for aidc_lite_ahb_sram_slave: two instances (zero-wait and three-wait),
// pipelined AHB driver, byte-level memory model and expected-read queue.
module tb_aidc_lite_ahb_sram_slave;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_2000;
  localparam int DEPTH0 = 256;
  localparam int DEPTH1 = 64;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic [1:0]  hresp     [2];
  logic [31:0] hrdata    [2];

  logic [31:0] mem_m [2][DEPTH0];
  xfer_t       seq_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  assign hready[0] = hreadyout[0];
  assign hready[1] = hreadyout[1];

  always #5 clk = ~clk;

  aidc_lite_ahb_sram_slave #(.BASE_ADDR(BASE0), .DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .hsel_i(hsel[0]), .haddr_i(haddr[0]), .htrans_i(htrans[0]),
    .hwrite_i(hwrite[0]), .hsize_i(hsize[0]), .hburst_i(hburst[0]), .hwdata_i(hwdata[0]),
    .hready_i(hready[0]), .hreadyout_o(hreadyout[0]), .hresp_o(hresp[0]), .hrdata_o(hrdata[0])
  );

  aidc_lite_ahb_sram_slave #(.BASE_ADDR(BASE1), .DEPTH_WORDS(DEPTH1), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .hsel_i(hsel[1]), .haddr_i(haddr[1]), .htrans_i(htrans[1]),
    .hwrite_i(hwrite[1]), .hsize_i(hsize[1]), .hburst_i(hburst[1]), .hwdata_i(hwdata[1]),
    .hready_i(hready[1]), .hreadyout_o(hreadyout[1]), .hresp_o(hresp[1]), .hrdata_o(hrdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic write,
                               input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write; x.addr = addr; x.size = size; x.wdata = wdata;
    return x;
  endfunction

  function automatic logic is_err(input int d, input xfer_t x);
    longint unsigned a, lo, hi;
    a  = longint'(x.addr);
    lo = longint'(base_of(d));
    hi = lo + longint'(depth_of(d)) * 4;
    if (a < lo || a >= hi) return 1'b1;
    if (x.size > 3'd2) return 1'b1;
    if (x.size == 3'd1 && (a % 2) != 0) return 1'b1;
    if (x.size == 3'd2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int word_of(input int d, input logic [31:0] addr);
    return int'((addr - base_of(d)) / 4);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH0; i++) mem_m[d][i] = '0;
  endtask

  // Bytes written: 1, 2 or 4 consecutive bytes starting at the address, taken from the matching lanes.
  task automatic model_write(input int d, input xfer_t x);
    int n, p, w;
    n = (x.size == 3'd0) ? 1 : (x.size == 3'd1) ? 2 : 4;
    w = word_of(d, x.addr);
    for (int k = 0; k < n; k++) begin
      p = int'(x.addr % 4) + k;
      mem_m[d][w][8*p +: 8] = x.wdata[8*p +: 8];
    end
  endtask

  task automatic drive(input int d, input xfer_t x, input logic [31:0] wd);
    hsel[d]   = x.sel;
    haddr[d]  = x.addr;
    htrans[d] = x.trans;
    hwrite[d] = x.write;
    hsize[d]  = x.size;
    hburst[d] = 3'($urandom_range(0, 7));
    hwdata[d] = wd;
  endtask

  // Runs seq_q through instance d as a pipelined master, checking every cycle.
  task automatic run_seq(input int d, input string name);
    xfer_t a, dp, idle_x;
    logic have_dp, dp_real, dp_err, rdy, exp_rdy;
    logic [1:0] rsp, exp_rsp;
    logic [31:0] rd, exp_rd;
    int cyc, budget;
    idle_x = mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
    dp = idle_x;
    have_dp = 1'b0; dp_real = 1'b0; dp_err = 1'b0;
    cyc = 0; budget = 0;
    exp_q.delete();
    while ((seq_q.size() > 0 || have_dp) && budget < 4000) begin
      a = (seq_q.size() > 0) ? seq_q[0] : idle_x;
      drive(d, a, have_dp ? dp.wdata : 32'h0);
      @(negedge clk);
      rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
      exp_rdy = 1'b1; exp_rsp = 2'b00; exp_rd = 32'h0;
      if (have_dp && dp_real) begin
        if (dp_err) begin
          exp_rdy = (cyc >= 1);
          exp_rsp = 2'b01;
        end else begin
          exp_rdy = (cyc >= waits_of(d));
          if (exp_rdy && !dp.write) exp_rd = exp_q[0];
        end
      end
      chk($sformatf("%s.d%0d.a%08h.c%0d.ready", name, d, dp.addr, cyc), {31'b0, rdy}, {31'b0, exp_rdy});
      chk($sformatf("%s.d%0d.a%08h.c%0d.resp", name, d, dp.addr, cyc), {30'b0, rsp}, {30'b0, exp_rsp});
      chk($sformatf("%s.d%0d.a%08h.c%0d.rdata", name, d, dp.addr, cyc), rd, exp_rd);
      @(posedge clk);
      #1;
      budget++;
      if (rdy) begin
        if (have_dp && dp_real && !dp_err) begin
          if (dp.write) model_write(d, dp);
          else if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (seq_q.size() > 0) begin
          dp = seq_q.pop_front();
          have_dp = 1'b1;
          dp_real = dp.sel && dp.trans[1];
          dp_err  = dp_real && is_err(d, dp);
          if (dp_real && !dp_err && !dp.write) exp_q.push_back(mem_m[d][word_of(d, dp.addr)]);
        end else begin
          have_dp = 1'b0;
        end
        cyc = 0;
      end else begin
        cyc++;
      end
    end
    if (budget >= 4000) begin
      chk($sformatf("%s.d%0d.timeout", name, d), 32'd1, 32'd0);
      seq_q.delete();
    end
    drive(d, idle_x, 32'h0);
  endtask

  task automatic gen_random(input int d, input int n);
    xfer_t x;
    int r, offs;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      x.sel   = ($urandom_range(0, 9) != 0);
      x.write = 1'($urandom_range(0, 1));
      x.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      offs    = $urandom_range(0, depth_of(d) * 4 - 1);
      if ($urandom_range(0, 7) != 0 && x.size <= 3'd2) offs = offs & ~((1 << x.size) - 1);
      if ($urandom_range(0, 9) == 0) offs = depth_of(d) * 4 + $urandom_range(0, 15);
      x.addr  = base_of(d) + 32'(offs);
      if (d == 1 && $urandom_range(0, 19) == 0) x.addr = base_of(d) - 32'($urandom_range(1, 8));
      x.wdata = $urandom;
      seq_q.push_back(x);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) drive(d, mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0), 32'h0);
    model_reset();

    // Outputs while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset.d%0d.ready", d), {31'b0, hreadyout[d]}, 32'd1);
      chk($sformatf("reset.d%0d.resp", d), {30'b0, hresp[d]}, 32'd0);
      chk($sformatf("reset.d%0d.rdata", d), hrdata[d], 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait instance: word write/read, lanes, errors, BUSY mid-burst.
    seq_q.push_back(mk(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF));
    seq_q.push_back(mk(1, 2'b10, 0, 32'h10, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 1, 32'h20, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 1, 32'h21, 3'd0, 32'h0000AB00));
    seq_q.push_back(mk(1, 2'b10, 1, 32'h22, 3'd1, 32'h12340000));
    seq_q.push_back(mk(1, 2'b10, 0, 32'h20, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 0, 32'h400, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 1, 32'h06, 3'd2, 32'hFFFFFFFF));
    seq_q.push_back(mk(1, 2'b10, 0, 32'h04, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 1, 32'h30, 3'd2, 32'hA5A50001));
    seq_q.push_back(mk(1, 2'b01, 1, 32'h34, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b11, 1, 32'h34, 3'd2, 32'hA5A50002));
    seq_q.push_back(mk(1, 2'b00, 0, 32'h38, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 0, 32'h30, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b01, 0, 32'h34, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b11, 0, 32'h34, 3'd2, 32'h0));
    run_seq(0, "dir0");

    // Three-wait instance: INCR4 write then read, below-base and above-end errors.
    for (int i = 0; i < 4; i++)
      seq_q.push_back(mk(1, (i == 0) ? 2'b10 : 2'b11, 1, BASE1 + 32'h40 + 32'(4 * i), 3'd2, 32'(i + 1)));
    for (int i = 0; i < 4; i++)
      seq_q.push_back(mk(1, (i == 0) ? 2'b10 : 2'b11, 0, BASE1 + 32'h40 + 32'(4 * i), 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 0, BASE1 - 32'h4, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 1, BASE1 + 32'h100, 3'd2, 32'h5));
    seq_q.push_back(mk(1, 2'b10, 0, BASE1 + 32'hFC, 3'd2, 32'h0));
    run_seq(1, "dir1");

    // Reset in the middle of a waited write: nothing is committed, array cleared.
    drive(1, mk(1, 2'b10, 1, BASE1 + 32'h80, 3'd2, 32'h0), 32'h0);
    @(posedge clk);
    #1 drive(1, mk(0, 2'b00, 0, 32'h0, 3'd0, 32'h0), 32'hCAFEF00D);
    @(negedge clk);
    chk("midrst.pre.ready", {31'b0, hreadyout[1]}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst.ready", {31'b0, hreadyout[1]}, 32'd1);
    chk("midrst.resp", {30'b0, hresp[1]}, 32'd0);
    chk("midrst.rdata", hrdata[1], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    seq_q.push_back(mk(1, 2'b10, 0, BASE1 + 32'h80, 3'd2, 32'h0));
    seq_q.push_back(mk(1, 2'b10, 0, BASE1 + 32'h40, 3'd2, 32'h0));
    run_seq(1, "postrst1");
    seq_q.push_back(mk(1, 2'b10, 0, 32'h10, 3'd2, 32'h0));
    run_seq(0, "postrst0");

    gen_random(0, 200);
    run_seq(0, "rand0");
    gen_random(1, 120);
    run_seq(1, "rand1");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
